// File: rtl/button_event_detector_pkg.sv
// Shared definitions for the button event path: FSM state encoding and the
// hold timing constants that the debouncer also derives its timing from.
package button_event_detector_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHORT = 2'd1,
      LONG  = 2'd2
   } btn_state_t;

   localparam int CLK_FREQ_HZ               = 50_000_000;
   localparam int DEFAULT_LONG_PRESS_CYCLES = CLK_FREQ_HZ;      // 1 s hold
   localparam int DEFAULT_REPEAT_CYCLES     = CLK_FREQ_HZ / 5;  // 200 ms repeat

   // Larger of two cycle counts; sizes the shared hold counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_detector_hold_timer.sv
// Hold counter: synchronous clear, count enable and a compare against a
// run-time terminal value. Clear wins over enable.
module hold_timer #(
   parameter int W = 8
) (
   input  logic         clk_fast,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] count,
   output logic         match
);

   logic [W-1:0] count_reg;

   // Count up while enabled; clear or reset returns the count to zero.
   always_ff @(posedge clk_fast) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;
   assign match = (count_reg == terminal);

endmodule

// File: rtl/button_event_detector.sv
// Turns the debounced active-low button level into one-cycle press, release,
// click, long-press and auto-repeat pulses plus a registered held level.
module button_event_detector
   import button_event_detector_pkg::*;
#(
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
   parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
   input  logic clk_fast,
   input  logic reset,
   input  logic btn_n,
   input  logic repeat_en,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int CNT_MAX = max_int(LONG_PRESS_CYCLES, REPEAT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

   btn_state_t       state_reg;
   logic [CNT_W-1:0] terminal;
   logic [CNT_W-1:0] timer_count;
   logic             timer_match;
   logic             timer_clear;
   logic             timer_en;

   hold_timer #(.W(CNT_W)) u_hold_timer (
      .clk_fast (clk_fast),
      .reset    (reset),
      .clear    (timer_clear),
      .enable   (timer_en),
      .terminal (terminal),
      .count    (timer_count),
      .match    (timer_match)
   );

   // Timer control: IDLE keeps the counter at zero so a press starts from 0;
   // threshold hits and disabled repeat clear it, otherwise a held button counts.
   always_comb begin
      terminal    = (state_reg == LONG) ? REPEAT_TERM : LONG_TERM;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      unique case (state_reg)
         IDLE: timer_clear = 1'b1;
         SHORT: begin
            if (!btn_n) begin
               if (timer_match) timer_clear = 1'b1;
               else             timer_en    = 1'b1;
            end
         end
         LONG: begin
            if (!btn_n) begin
               if (!repeat_en || timer_match) timer_clear = 1'b1;
               else                           timer_en    = 1'b1;
            end
         end
         default: timer_clear = 1'b1;
      endcase
   end

   // Event FSM with registered pulse outputs; release beats threshold matches.
   always_ff @(posedge clk_fast) begin
      if (reset) begin
         state_reg     <= IDLE;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         unique case (state_reg)
            IDLE: begin
               if (!btn_n) begin
                  press_pulse <= 1'b1;
                  held        <= 1'b1;
                  state_reg   <= SHORT;
               end
            end
            SHORT: begin
               if (btn_n) begin
                  release_pulse <= 1'b1;
                  click_pulse   <= 1'b1;
                  held          <= 1'b0;
                  state_reg     <= IDLE;
               end else if (timer_match) begin
                  long_pulse <= 1'b1;
                  state_reg  <= LONG;
               end
            end
            LONG: begin
               if (btn_n) begin
                  release_pulse <= 1'b1;
                  held          <= 1'b0;
                  state_reg     <= IDLE;
               end else if (repeat_en && timer_match) begin
                  repeat_pulse <= 1'b1;
               end
            end
            default: begin
               held      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector with LONG_PRESS_CYCLES=8 and
// REPEAT_CYCLES=4. Output vector order: press,release,click,long,repeat,held.
module tb_button_event_detector;

   logic clk_fast = 1'b0;
   logic reset    = 1'b1;
   logic btn_n    = 1'b1;
   logic repeat_en = 1'b0;
   logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] O_ZERO = 6'b000000;
   localparam logic [5:0] O_PRESS = 6'b100001;
   localparam logic [5:0] O_HELD = 6'b000001;
   localparam logic [5:0] O_CLICK = 6'b011000;
   localparam logic [5:0] O_REL = 6'b010000;
   localparam logic [5:0] O_LONG = 6'b000101;
   localparam logic [5:0] O_REP = 6'b000011;

   button_event_detector #(
      .LONG_PRESS_CYCLES (8),
      .REPEAT_CYCLES     (4)
   ) dut (
      .clk_fast      (clk_fast),
      .reset         (reset),
      .btn_n         (btn_n),
      .repeat_en     (repeat_en),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click_pulse   (click_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held)
   );

   always #5 clk_fast = ~clk_fast;

   // Advance one rising edge and settle so outputs reflect that edge.
   task automatic tick();
      @(posedge clk_fast);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
      checks++;
      assert (obs === exp)
         $display("ok   %s outputs=%b", tag, obs);
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected vector k edges after the press edge while btn_n stays 0.
   function automatic logic [5:0] hold_exp(input int k, input logic ren);
      if (k == 8) return O_LONG;
      if (ren && k > 8 && ((k - 8) % 4 == 0)) return O_REP;
      return O_HELD;
   endfunction

   initial begin
      // Reset held for 3 cycles with button released.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset_cyc%0d", i), O_ZERO);
      end
      reset = 1'b0;
      tick();
      chk("post_reset_idle", O_ZERO);

      // Short click: 5 edges sample btn_n=0, then release.
      btn_n = 1'b0;
      tick();
      chk("click_press", O_PRESS);
      for (int k = 1; k < 5; k++) begin
         tick();
         chk($sformatf("click_hold_k%0d", k), O_HELD);
      end
      btn_n = 1'b1;
      tick();
      chk("click_release", O_CLICK);
      tick();
      chk("click_idle", O_ZERO);

      // Long press with repeat: 20 edges sample btn_n=0.
      repeat_en = 1'b1;
      btn_n = 1'b0;
      tick();
      chk("lrep_press", O_PRESS);
      for (int k = 1; k < 20; k++) begin
         tick();
         chk($sformatf("lrep_k%0d", k), hold_exp(k, 1'b1));
      end
      btn_n = 1'b1;
      tick();
      chk("lrep_release", O_REL);
      tick();
      chk("lrep_idle", O_ZERO);

      // Long press without repeat.
      repeat_en = 1'b0;
      btn_n = 1'b0;
      tick();
      chk("lnorep_press", O_PRESS);
      for (int k = 1; k < 20; k++) begin
         tick();
         chk($sformatf("lnorep_k%0d", k), hold_exp(k, 1'b0));
      end
      btn_n = 1'b1;
      tick();
      chk("lnorep_release", O_REL);
      tick();
      chk("lnorep_idle", O_ZERO);

      // Boundary: release sampled on the edge where cnt=7.
      repeat_en = 1'b1;
      btn_n = 1'b0;
      tick();
      chk("bnd_press", O_PRESS);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("bnd_k%0d", k), O_HELD);
      end
      btn_n = 1'b1;
      tick();
      chk("bnd_release", O_CLICK);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bnd_idle%0d", i), O_ZERO);
      end

      // Reset while in LONG, button still held through deassert.
      btn_n = 1'b0;
      tick();
      chk("rst_press", O_PRESS);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("rst_hold_k%0d", k), hold_exp(k, 1'b1));
      end
      reset = 1'b1;
      tick();
      chk("rst_mid_long0", O_ZERO);
      tick();
      chk("rst_mid_long1", O_ZERO);
      reset = 1'b0;
      tick();
      chk("rst_repress", O_PRESS);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("rst_relong_k%0d", k), hold_exp(k, 1'b1));
      end
      btn_n = 1'b1;
      tick();
      chk("rst_release", O_REL);
      tick();
      chk("rst_idle", O_ZERO);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
